// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: operand/request and HI/LO result bundle between the execute stage and the multiply/divide unit.
interface mdu_hilo_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative 32-bit multiply/divide unit holding the HI/LO registers.
// Define MDU_FAST_MUL_EN to replace the 32-cycle shift-add multiply with a single-cycle product.
module mdu_hilo (
    input logic       clk,
    input logic       rst,
    mdu_hilo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
    logic        div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
    logic        go, fast, sgn, ge;
    logic [31:0] abs_a, abs_b, rem;
    logic [32:0] sh, msum;
    assign sgn   = !bus.op[0];
    assign go    = bus.start && state_q == IDLE && !bus.op[2];
    assign abs_a = (sgn && bus.a[31]) ? -bus.a : bus.a;
    assign abs_b = (sgn && bus.b[31]) ? -bus.b : bus.b;
`ifdef MDU_FAST_MUL_EN
    assign fast = !bus.op[1];
`else
    assign fast = 1'b0;
`endif
    // acc holds {remainder, quotient} for divide and {partial product, multiplier} for multiply
    assign sh   = acc_q[63:31];
    assign ge   = sh >= {1'b0, opd_q};
    assign rem  = sh[31:0] - opd_q;
    assign msum = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? opd_q : 32'd0};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? (go ? (fast ? FIX : CALC) : IDLE)
                : state_q == CALC ? (cnt_q == 5'd31 ? FIX : CALC)
                : IDLE;
    end
    always_comb begin
        bus.busy = state_q != IDLE;
        bus.done = done_q;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opd_d  = opd_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (go) begin
            cnt_d  = 5'd0;
            div_d  = bus.op[1];
            opd_d  = bus.op[1] ? abs_b : abs_a;
            acc_d  = fast ? {32'd0, abs_a} * {32'd0, abs_b} : {32'd0, bus.op[1] ? abs_a : abs_b};
            neg_d  = sgn && (bus.a[31] ^ bus.b[31]);
            rneg_d = sgn && bus.a[31];
            dz_d   = bus.b == 32'd0;
        end else if (bus.start && state_q == IDLE && bus.op[2:1] == 2'b10) begin
            hi_d = bus.op[0] ? hi_q : bus.a;
            lo_d = bus.op[0] ? bus.a : lo_q;
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + 5'd1;
            acc_d = div_q ? {ge ? rem : sh[31:0], acc_q[30:0], ge} : {msum, acc_q[31:1]};
        end else if (state_q == FIX) begin
            done_d = 1'b1;
            // divide-by-zero keeps the all-ones quotient regardless of operand signs
            lo_d = div_q ? ((neg_q && !dz_q) ? -acc_q[31:0] : acc_q[31:0])
                         : (neg_q ? lo_of(-acc_q) : acc_q[31:0]);
            hi_d = div_q ? (rneg_q ? -acc_q[63:32] : acc_q[63:32])
                         : (neg_q ? hi_of(-acc_q) : acc_q[63:32]);
        end
    end
    function automatic logic [31:0] lo_of(input logic [63:0] v);
        return v[31:0];
    endfunction
    function automatic logic [31:0] hi_of(input logic [63:0] v);
        return v[63:32];
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 5'd0;
            acc_q  <= 64'd0;
            opd_q  <= 32'd0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opd_q  <= opd_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed checks of mdu_hilo multiply, divide, HI/LO moves, busy/done timing and reset.
module tb_mdu_hilo;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    mdu_hilo_if bus ();
    mdu_hilo dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int bc, output int dc);
        pulse(op, a, b);
        bc = 0;
        dc = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.busy) bc++;
            if (bus.done) dc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
        rst = 1'b0;
    endtask

    task automatic test_mul;
        int bc, dc;
        run_op(3'b001, 32'hFFFF_FFFF, 32'd2, bc, dc);
        checks++; if (bus.hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi got %h exp 00000001", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h exp fffffffe", bus.lo); end
        checks++; if (bc !== MUL_LAT) begin errors++; $display("FAIL multu_busy_cycles got %0d exp %0d", bc, MUL_LAT); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL multu_done_pulses got %0d exp 1", dc); end
        run_op(3'b000, 32'hFFFF_FFFD, 32'd5, bc, dc);
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h exp fffffff1", bus.lo); end
        run_op(3'b000, 32'h8000_0000, 32'h8000_0000, bc, dc);
        checks++; if (bus.hi !== 32'h4000_0000) begin errors++; $display("FAIL mult_minmin_hi got %h exp 40000000", bus.hi); end
        checks++; if (bus.lo !== 32'h0000_0000) begin errors++; $display("FAIL mult_minmin_lo got %h exp 00000000", bus.lo); end
    endtask

    task automatic test_div;
        int bc, dc;
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, bc, dc);
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", bus.hi); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL div_busy_cycles got %0d exp 33", bc); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL div_done_pulses got %0d exp 1", dc); end
        run_op(3'b011, 32'd100, 32'd7, bc, dc);
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h exp 0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h exp 00000002", bus.hi); end
        run_op(3'b010, 32'd7, 32'hFFFF_FFFE, bc, dc);
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_posneg_lo got %h exp fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL div_posneg_hi got %h exp 00000001", bus.hi); end
    endtask

    task automatic test_div_zero;
        int bc, dc;
        run_op(3'b011, 32'd7, 32'd0, bc, dc);
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got %h exp ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'd7) begin errors++; $display("FAIL divu0_hi got %h exp 00000007", bus.hi); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL divu0_busy_cycles got %0d exp 33", bc); end
        run_op(3'b010, 32'hFFFF_FFF8, 32'd0, bc, dc);
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h exp ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFF8) begin errors++; $display("FAIL div0_hi got %h exp fffffff8", bus.hi); end
    endtask

    task automatic test_div_overflow;
        int bc, dc;
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
        checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h exp 80000000", bus.lo); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL divovf_hi got %h exp 00000000", bus.hi); end
    endtask

    task automatic test_mthi_mtlo;
        pulse(3'b100, 32'h1234_5678, 32'd0);
        checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", bus.hi); end
        checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL mthi_lo_kept got %h exp 80000000", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mthi_done got %b exp 0", bus.done); end
        pulse(3'b101, 32'h0BAD_CAFE, 32'd0);
        checks++; if (bus.lo !== 32'h0BAD_CAFE) begin errors++; $display("FAIL mtlo_lo got %h exp 0badcafe", bus.lo); end
        checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_kept got %h exp 12345678", bus.hi); end
    endtask

    task automatic test_mtlo_mid_div;
        pulse(3'b011, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        checks++; if (bus.lo !== 32'h0BAD_CAFE) begin errors++; $display("FAIL busy_stale_lo got %h exp 0badcafe", bus.lo); end
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.a     = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.lo !== 32'h0BAD_CAFE) begin errors++; $display("FAIL mid_mtlo_lo got %h exp 0badcafe", bus.lo); end
        repeat (40) @(negedge clk);
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL mid_mtlo_final_lo got %h exp 0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL mid_mtlo_final_hi got %h exp 00000002", bus.hi); end
    endtask

    task automatic test_reserved;
        pulse(3'b110, 32'hCAFE_F00D, 32'd1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rsv110_busy got %b exp 0", bus.busy); end
        pulse(3'b111, 32'hCAFE_F00D, 32'd1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rsv111_busy got %b exp 0", bus.busy); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL rsv_hi got %h exp 00000002", bus.hi); end
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL rsv_lo got %h exp 0000000e", bus.lo); end
    endtask

    task automatic test_back_to_back;
        bit seen = 1'b0;
        pulse(3'b011, 32'd50, 32'd6);
        for (int i = 0; i < 60; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_done_seen got %b exp 1", seen); end
        checks++; if (bus.lo !== 32'd8) begin errors++; $display("FAIL b2b_first_lo got %h exp 00000008", bus.lo); end
        bus.start = 1'b1;
        bus.op    = 3'b011;
        bus.a     = 32'd7;
        bus.b     = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got %b exp 1", bus.busy); end
        repeat (40) @(negedge clk);
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_second_lo got %h exp ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'd7) begin errors++; $display("FAIL b2b_second_hi got %h exp 00000007", bus.hi); end
    endtask

    task automatic test_reset_mid_calc;
        int bc, dc;
        pulse(3'b100, 32'hAAAA_AAAA, 32'd0);
        pulse(3'b101, 32'h5555_5555, 32'd0);
        pulse(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi got %h exp 0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo got %h exp 0", bus.lo); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", bus.done); end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b001, 32'd3, 32'd4, bc, dc);
        checks++; if (bus.lo !== 32'd12) begin errors++; $display("FAIL postrst_lo got %h exp 0000000c", bus.lo); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL postrst_hi got %h exp 0", bus.hi); end
        checks++; if (bc !== MUL_LAT) begin errors++; $display("FAIL postrst_busy_cycles got %0d exp %0d", bc, MUL_LAT); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL postrst_done_pulses got %0d exp 1", dc); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_div_overflow();
        test_mthi_mtlo();
        test_mtlo_mid_div();
        test_reserved();
        test_back_to_back();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
